// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, IR field positions, state encoding and strobe bundle shared by the control unit
package control_unit_pkg;

    localparam int NREG = 16;
    localparam int OPW  = 5;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_ADD  = 5'b00011;
    localparam op_t OP_SUB  = 5'b00100;
    localparam op_t OP_AND  = 5'b00101;
    localparam op_t OP_OR   = 5'b00110;
    localparam op_t OP_SHR  = 5'b00111;
    localparam op_t OP_SHL  = 5'b01000;
    localparam op_t OP_ROR  = 5'b01001;
    localparam op_t OP_ROL  = 5'b01010;
    localparam op_t OP_MUL  = 5'b01111;
    localparam op_t OP_DIV  = 5'b10000;
    localparam op_t OP_NEG  = 5'b10001;
    localparam op_t OP_NOT  = 5'b10010;
    localparam op_t OP_NOP  = 5'b11010;
    localparam op_t OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_END  = 4'd9,
        S_HALT = 4'd10,
        S_ERR  = 4'd11
    } state_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } instr_t;

    typedef struct packed {
        logic pc_out;
        logic mdr_out;
        logic zlo_out;
        logic zhi_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic zlo_in;
        logic zhi_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic busy;
        logic err;
        op_t  control;
    } strobes_t;

    function automatic instr_t decode(input logic [31:0] ir);
        return '{op: ir[OP_HI:OP_LO], ra: ir[RA_HI:RA_LO], rb: ir[RB_HI:RB_LO], rc: ir[RC_HI:RC_LO]};
    endfunction

    function automatic logic is_binary(input op_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
    endfunction

    function automatic logic is_muldiv(input op_t op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

    function automatic logic is_unary(input op_t op);
        return op == OP_NEG || op == OP_NOT;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction-side inputs and Datapath strobe outputs of the control unit
interface control_unit_if;
    import control_unit_pkg::*;

    logic            Run;
    logic            Mem_Rdy;
    logic [31:0]     IR;
    logic            PC_Out;
    logic            MDR_Out;
    logic            ZLO_Out;
    logic            ZHI_Out;
    logic            PC_In;
    logic            MAR_In;
    logic            MDR_In;
    logic            IR_In;
    logic            Y_In;
    logic            ZLO_In;
    logic            ZHI_In;
    logic            HI_In;
    logic            LO_In;
    logic            IncPC;
    logic            Read;
    logic [NREG-1:0] R_Out;
    logic [NREG-1:0] R_In;
    logic [OPW-1:0]  CONTROL;
    logic            Busy;
    logic            Err;

    modport master (
        input  Run, Mem_Rdy, IR,
        output PC_Out, MDR_Out, ZLO_Out, ZHI_Out,
        output PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In, ZHI_In, HI_In, LO_In,
        output IncPC, Read, R_Out, R_In, CONTROL, Busy, Err
    );

    modport slave (
        output Run, Mem_Rdy, IR,
        input  PC_Out, MDR_Out, ZLO_Out, ZHI_Out,
        input  PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In, ZHI_In, HI_In, LO_In,
        input  IncPC, Read, R_Out, R_In, CONTROL, Busy, Err
    );

endinterface

// File: rtl/control_unit_reg_select.sv
// control_unit_reg_select: 4-bit register field plus enable to a one-hot register-select bus
module control_unit_reg_select
    import control_unit_pkg::*;
#(
    parameter int N = NREG
) (
    input  logic [3:0]   field,
    input  logic         en,
    output logic [N-1:0] onehot
);

    assign onehot = en ? N'(1) << field : '0;

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing Datapath fetch and register-register ALU execute
module control_unit
    import control_unit_pkg::*;
(
    input  logic           Clock,
    input  logic           Clear,
    control_unit_if.master bus
);

    state_t          state, nxt;
    instr_t          ir_q, ins;
    strobes_t        s_d, s_q;
    logic [NREG-1:0] r_in_d, r_in_q, r_out_a, r_out_b, r_out_q;
    logic [3:0]      fa, fb;
    logic            md, bin, un;

    // in T2 the IR is being loaded, so the decision out of T2 looks at the live IR
    assign ins = state == S_T2 ? decode(bus.IR) : ir_q;
    assign md  = is_muldiv(ins.op);
    assign bin = is_binary(ins.op);
    assign un  = is_unary(ins.op);
    assign fa  = md ? ins.ra : ins.rb;
    assign fb  = bin ? ins.rc : ins.rb;

    control_unit_reg_select u_in (.field(ins.ra), .en(nxt == S_T5 && !md), .onehot(r_in_d));
    control_unit_reg_select u_t3 (.field(fa), .en(nxt == S_T3), .onehot(r_out_a));
    control_unit_reg_select u_t4 (.field(fb), .en(nxt == S_T4), .onehot(r_out_b));

    // state, latched instruction fields and registered strobes; Clear overrides everything
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            s_q     <= '0;
            r_in_q  <= '0;
            r_out_q <= '0;
        end else begin
            state   <= nxt;
            s_q     <= s_d;
            r_in_q  <= r_in_d;
            r_out_q <= r_out_a | r_out_b;
            if (state == S_T2)
                ir_q <= decode(bus.IR);
        end
    end

    // next-state sequencing through fetch, decode and the per-class execute steps
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = bus.Run ? S_T0 : S_IDLE;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = bus.Mem_Rdy ? S_T2 : S_T1W;
            S_T1W:   nxt = bus.Mem_Rdy ? S_T2 : S_T1W;
            S_T2:    nxt = (bin || md) ? S_T3 :
                           un ? S_T4 :
                           ins.op == OP_NOP ? S_END :
                           ins.op == OP_HALT ? S_HALT : S_ERR;
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = md ? S_T6 : S_END;
            S_T6:    nxt = S_END;
            S_END:   nxt = bus.Run ? S_T0 : S_HALT;
            S_HALT:  nxt = S_HALT;
            S_ERR:   nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
    end

    // strobes decoded from the next state so the registered outputs line up with the state register
    always_comb begin
        s_d         = '0;
        s_d.pc_out  = nxt == S_T0;
        s_d.mdr_out = nxt == S_T2;
        s_d.zlo_out = nxt inside {S_T1, S_T5};
        s_d.zhi_out = nxt == S_T6;
        s_d.pc_in   = nxt == S_T1;
        s_d.mar_in  = nxt == S_T0;
        s_d.mdr_in  = nxt inside {S_T1, S_T1W};
        s_d.ir_in   = nxt == S_T2;
        s_d.y_in    = nxt == S_T3;
        s_d.zlo_in  = nxt inside {S_T0, S_T4};
        s_d.zhi_in  = nxt == S_T4 && md;
        s_d.hi_in   = nxt == S_T6;
        s_d.lo_in   = nxt == S_T5 && md;
        s_d.inc_pc  = nxt == S_T0;
        s_d.read    = nxt inside {S_T1, S_T1W};
        s_d.busy    = !(nxt inside {S_IDLE, S_HALT, S_ERR});
        s_d.err     = nxt == S_ERR;
        s_d.control = nxt == S_T4 ? ins.op : '0;
    end

    // the shared Datapath bus never has two drivers in one cycle
    always_ff @(posedge Clock) begin
        if (!Clear)
            assert ($onehot0({s_q.pc_out, s_q.mdr_out, s_q.zlo_out, s_q.zhi_out, |r_out_q}));
    end

    assign bus.PC_Out  = s_q.pc_out;
    assign bus.MDR_Out = s_q.mdr_out;
    assign bus.ZLO_Out = s_q.zlo_out;
    assign bus.ZHI_Out = s_q.zhi_out;
    assign bus.PC_In   = s_q.pc_in;
    assign bus.MAR_In  = s_q.mar_in;
    assign bus.MDR_In  = s_q.mdr_in;
    assign bus.IR_In   = s_q.ir_in;
    assign bus.Y_In    = s_q.y_in;
    assign bus.ZLO_In  = s_q.zlo_in;
    assign bus.ZHI_In  = s_q.zhi_in;
    assign bus.HI_In   = s_q.hi_in;
    assign bus.LO_In   = s_q.lo_in;
    assign bus.IncPC   = s_q.inc_pc;
    assign bus.Read    = s_q.read;
    assign bus.Busy    = s_q.busy;
    assign bus.Err     = s_q.err;
    assign bus.CONTROL = s_q.control;
    assign bus.R_Out   = r_out_q;
    assign bus.R_In    = r_in_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences with a per-cycle expected-strobe scoreboard
module tb_control_unit;
  typedef logic [53:0] vec_t;
  typedef struct {
    int    cyc;
    string name;
    vec_t  v;
  } exp_t;
  localparam vec_t PCO  = 54'd1 << 53;
  localparam vec_t MDRO = 54'd1 << 52;
  localparam vec_t ZLOO = 54'd1 << 51;
  localparam vec_t ZHIO = 54'd1 << 50;
  localparam vec_t PCI  = 54'd1 << 49;
  localparam vec_t MARI = 54'd1 << 48;
  localparam vec_t MDRI = 54'd1 << 47;
  localparam vec_t IRI  = 54'd1 << 46;
  localparam vec_t YI   = 54'd1 << 45;
  localparam vec_t ZLOI = 54'd1 << 44;
  localparam vec_t ZHII = 54'd1 << 43;
  localparam vec_t HII  = 54'd1 << 42;
  localparam vec_t LOI  = 54'd1 << 41;
  localparam vec_t INC  = 54'd1 << 40;
  localparam vec_t RD   = 54'd1 << 39;
  localparam vec_t BSY  = 54'd1 << 38;
  localparam vec_t ERR  = 54'd1 << 37;
  localparam vec_t E_T0  = PCO | MARI | INC | ZLOI | BSY;
  localparam vec_t E_T1  = ZLOO | PCI | RD | MDRI | BSY;
  localparam vec_t E_T1W = RD | MDRI | BSY;
  localparam vec_t E_T2  = MDRO | IRI | BSY;
  logic Clock = 1'b0;
  logic Clear = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;
  vec_t got;
  control_unit_if bus();
  control_unit dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus  (bus)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  assign got = {bus.PC_Out, bus.MDR_Out, bus.ZLO_Out, bus.ZHI_Out, bus.PC_In, bus.MAR_In,
                bus.MDR_In, bus.IR_In, bus.Y_In, bus.ZLO_In, bus.ZHI_In, bus.HI_In, bus.LO_In,
                bus.IncPC, bus.Read, bus.Busy, bus.Err, bus.CONTROL, bus.R_Out, bus.R_In};
  function automatic vec_t ctl(input logic [4:0] op);
    return vec_t'(op) << 32;
  endfunction
  function automatic vec_t ro(input int n);
    return 54'd1 << (16 + n);
  endfunction
  function automatic vec_t ri(input int n);
    return 54'd1 << n;
  endfunction
  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction
  always @(negedge Clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != cyc || got !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.cyc, got, e.v);
      end
    end
  end
  initial begin
    repeat (2000) @(posedge Clock);
    n_chk++;
    n_fail++;
    $display("FAIL timeout: sequence did not finish, %0d expectations pending", q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  task automatic tick(input string name, input vec_t v);
    q.push_back('{cyc + 1, name, v});
    @(posedge Clock);
    #1;
  endtask
  task automatic fetch(input string name);
    tick({name, "_t0"}, E_T0);
    tick({name, "_t1"}, E_T1);
    tick({name, "_t2"}, E_T2);
  endtask
  task automatic do_clear(input string name);
    Clear = 1'b1;
    tick(name, '0);
    Clear = 1'b0;
  endtask
  initial begin
    bus.Run     = 1'b1;
    bus.Mem_Rdy = 1'b1;
    bus.IR      = enc(5'b00110, 4'd5, 4'd2, 4'd4);
    Clear       = 1'b1;
    tick("reset_a", '0);
    tick("reset_b", '0);
    n_chk++;
    if (got !== '0 || bus.Busy !== 1'b0 || bus.Err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%h busy=%b err=%b", got, bus.Busy, bus.Err);
    end
    Clear = 1'b0;
    fetch("or");
    tick("or_t3", BSY | YI | ro(2));
    tick("or_t4", BSY | ZLOI | ctl(5'b00110) | ro(4));
    tick("or_t5", BSY | ZLOO | ri(5));
    tick("or_end", BSY);
    bus.IR = enc(5'b11011, 4'd0, 4'd0, 4'd0);
    fetch("halt");
    tick("halt_st", '0);
    repeat (3) tick("halt_stay", '0);
    do_clear("clr_w");
    bus.Mem_Rdy = 1'b0;
    bus.IR      = enc(5'b10001, 4'd7, 4'd9, 4'd0);
    tick("w_t0", E_T0);
    tick("w_t1", E_T1);
    tick("w_t1a", E_T1W);
    tick("w_t1b", E_T1W);
    tick("w_t1c", E_T1W);
    bus.Mem_Rdy = 1'b1;
    tick("w_t2", E_T2);
    bus.Run = 1'b0;
    tick("neg_t4", BSY | ZLOI | ctl(5'b10001) | ro(9));
    tick("neg_t5", BSY | ZLOO | ri(7));
    tick("neg_end", BSY);
    tick("neg_halt", '0);
    do_clear("clr_mul");
    bus.Run = 1'b1;
    bus.IR  = enc(5'b01111, 4'd3, 4'd4, 4'd0);
    fetch("mul");
    tick("mul_t3", BSY | YI | ro(3));
    tick("mul_t4", BSY | ZLOI | ZHII | ctl(5'b01111) | ro(4));
    tick("mul_t5", BSY | ZLOO | LOI);
    tick("mul_t6", BSY | ZHIO | HII);
    tick("mul_end", BSY);
    bus.IR = enc(5'b11010, 4'd1, 4'd1, 4'd1);
    fetch("nop");
    tick("nop_end", BSY);
    bus.Run = 1'b0;
    tick("nop_halt", '0);
    do_clear("clr_ill");
    bus.Run = 1'b1;
    bus.IR  = enc(5'b11111, 4'd2, 4'd3, 4'd4);
    fetch("ill");
    tick("ill_err", ERR);
    repeat (10) tick("ill_sticky", ERR);
    Clear = 1'b1;
    tick("ill_clr", '0);
    Clear   = 1'b0;
    bus.Run = 1'b0;
    tick("ill_idle", '0);
    bus.Run = 1'b1;
    bus.IR  = enc(5'b00011, 4'd1, 4'd2, 4'd3);
    fetch("add");
    tick("add_t3", BSY | YI | ro(2));
    bus.Run = 1'b0;
    tick("add_t4", BSY | ZLOI | ctl(5'b00011) | ro(3));
    tick("add_t5", BSY | ZLOO | ri(1));
    tick("add_end", BSY);
    tick("add_halt", '0);
    tick("add_halt2", '0);
    do_clear("clr_mid");
    bus.Run = 1'b1;
    bus.IR  = enc(5'b00011, 4'd10, 4'd11, 4'd12);
    fetch("mid");
    tick("mid_t3", BSY | YI | ro(11));
    tick("mid_t4", BSY | ZLOI | ctl(5'b00011) | ro(12));
    Clear = 1'b1;
    tick("mid_clr_a", '0);
    tick("mid_clr_b", '0);
    Clear   = 1'b0;
    bus.Run = 1'b0;
    tick("mid_idle_a", '0);
    tick("mid_idle_b", '0);
    @(negedge Clock);
    @(negedge Clock);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL expired_wait: %0d expectations never checked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
